// File: rtl/moo_ccm_ctl_if.sv
// rtl/moo_ccm_ctl_if.sv - control/handshake bundle between the CCM MAC sequencer and its environment
interface moo_ccm_ctl_if;
  logic        clr_core;
  logic        start;
  logic        abort;
  logic        dec_mode;
  logic [31:0] size_msg;
  logic        ecb_done;
  logic        blk_vld;
  logic [1:0]  ccm_d_op;
  logic        ccm_d_en;
  logic        ccm_d_clr;
  logic        msg_done;
  logic        ecb_start;
  logic        blk_ack;
  logic        mac_done;
  logic        busy;

  // environment side: issues commands, ECB completions and message blocks
  modport master (
    output clr_core, start, abort, dec_mode, size_msg, ecb_done, blk_vld,
    input  ccm_d_op, ccm_d_en, ccm_d_clr, msg_done, ecb_start, blk_ack, mac_done, busy
  );

  // controller side
  modport slave (
    input  clr_core, start, abort, dec_mode, size_msg, ecb_done, blk_vld,
    output ccm_d_op, ccm_d_en, ccm_d_clr, msg_done, ecb_start, blk_ack, mac_done, busy
  );
endinterface

// File: rtl/moo_ccm_ctl.sv
// rtl/moo_ccm_ctl.sv - CCM MAC pass sequencer (B0 load, ECB rounds, message block loads)
module moo_ccm_ctl (
  input  logic           clk,
  input  logic           rst_n,
  moo_ccm_ctl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_B0    = 3'd1,
    ECB_GO   = 3'd2,
    ECB_WAIT = 3'd3,
    LD_ECB   = 3'd4,
    MSG_WAIT = 3'd5,
    LD_MSG   = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [1:0] OP_B0  = 2'b00;
  localparam logic [1:0] OP_ECB = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_ENC = 2'b11;

  state_t      state;
  logic [28:0] cnt;
  logic        dec_q;
  logic [28:0] nblk;

  // block count rounds a partial trailing block up to a whole one
  assign nblk = {1'b0, bus.size_msg[31:4]} + {28'd0, (bus.size_msg[3:0] != 4'd0)};

  // Sequencer: every output is registered alongside the state it belongs to,
  // so each branch loads the output values of the state it moves into.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dec_q         <= 1'b0;
      bus.ccm_d_op  <= OP_B0;
      bus.ccm_d_en  <= 1'b0;
      bus.ccm_d_clr <= 1'b0;
      bus.msg_done  <= 1'b0;
      bus.ecb_start <= 1'b0;
      bus.blk_ack   <= 1'b0;
      bus.mac_done  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ccm_d_op  <= OP_B0;
      bus.ccm_d_en  <= 1'b0;
      bus.ccm_d_clr <= 1'b0;
      bus.msg_done  <= 1'b0;
      bus.ecb_start <= 1'b0;
      bus.blk_ack   <= 1'b0;
      bus.mac_done  <= 1'b0;
      if (bus.clr_core) begin
        // datapath clears itself on clr_core, so no ccm_d_clr here
        state    <= IDLE;
        cnt      <= '0;
        bus.busy <= 1'b0;
      end else if (bus.abort && (state != IDLE)) begin
        state         <= IDLE;
        cnt           <= '0;
        bus.ccm_d_clr <= 1'b1;
        bus.busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state        <= LD_B0;
              dec_q        <= bus.dec_mode;
              cnt          <= nblk;
              bus.ccm_d_en <= 1'b1;
              bus.busy     <= 1'b1;
            end
          end
          LD_B0: begin
            state         <= ECB_GO;
            bus.ecb_start <= 1'b1;
          end
          ECB_GO: begin
            state <= ECB_WAIT;
          end
          ECB_WAIT: begin
            if (bus.ecb_done) begin
              state        <= LD_ECB;
              bus.ccm_d_op <= OP_ECB;
              bus.ccm_d_en <= 1'b1;
            end
          end
          LD_ECB: begin
            if (cnt == '0) begin
              state        <= DONE;
              bus.mac_done <= 1'b1;
            end else begin
              state        <= MSG_WAIT;
              bus.msg_done <= (cnt == 29'd1);
            end
          end
          MSG_WAIT: begin
            bus.msg_done <= (cnt == 29'd1);
            if (bus.blk_vld) begin
              state        <= LD_MSG;
              bus.ccm_d_op <= dec_q ? OP_DEC : OP_ENC;
              bus.ccm_d_en <= 1'b1;
              bus.blk_ack  <= 1'b1;
            end
          end
          LD_MSG: begin
            state         <= ECB_GO;
            cnt           <= cnt - 29'd1;
            bus.ecb_start <= 1'b1;
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moo_ccm_ctl.sv
// tb/tb_moo_ccm_ctl.sv - scoreboard bench for moo_ccm_ctl
module tb_moo_ccm_ctl;
  logic clk;
  logic rst_n;
  logic ecb_auto;
  logic ecb_man;
  logic ecb_en;
  int   cd;

  moo_ccm_ctl_if bus();

  moo_ccm_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.ecb_done = ecb_auto | ecb_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ecb, n_ack, n_mac, n_clr, n_msg;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] model_nblk(input logic [31:0] sz);
    return {1'b0, sz[31:4]} + ((sz % 16) != 0 ? 29'd1 : 29'd0);
  endfunction

  // expected datapath-load / mac_done events: {mac_done, en, op, blk_ack, msg_done}
  task automatic push_model(input logic [31:0] sz, input bit dm);
    logic [28:0] nb;
    nb = model_nblk(sz);
    exp_q.push_back(6'b0_1_00_0_0);
    exp_q.push_back(6'b0_1_01_0_0);
    for (int i = 0; i < int'(nb); i++) begin
      exp_q.push_back({2'b01, (dm ? 2'b10 : 2'b11), 1'b1, (i == int'(nb) - 1)});
      exp_q.push_back(6'b0_1_01_0_0);
    end
    exp_q.push_back(6'b1_0_00_0_0);
  endtask

  // ECB engine stand-in: ecb_done three cycles after each ecb_start
  always @(negedge clk) begin
    if (!rst_n) begin
      cd = 0;
      ecb_auto = 1'b0;
    end else begin
      ecb_auto = 1'b0;
      if (cd != 0) begin
        cd = cd - 1;
        if (cd == 0) ecb_auto = 1'b1;
      end
      if (ecb_en && bus.ecb_start) cd = 3;
    end
  end

  // output monitor: pops the scoreboard on each load/mac_done event
  always @(negedge clk) begin
    logic [5:0] tok;
    if (rst_n) begin
      if (bus.ecb_start) n_ecb++;
      if (bus.blk_ack)   n_ack++;
      if (bus.mac_done)  n_mac++;
      if (bus.ccm_d_clr) n_clr++;
      if (bus.msg_done)  n_msg++;
      if (bus.ccm_d_en || bus.mac_done) begin
        tok = {bus.mac_done, bus.ccm_d_en, bus.ccm_d_op, bus.blk_ack, bus.msg_done};
        if (exp_q.size() == 0) chk("spurious_evt", 64'(tok), 64'd0);
        else chk("evt", 64'(tok), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [8:0] outs();
    return {bus.ccm_d_op, bus.ccm_d_en, bus.ccm_d_clr, bus.msg_done,
            bus.ecb_start, bus.blk_ack, bus.mac_done, bus.busy};
  endfunction

  task automatic clr_counts();
    n_ecb = 0; n_ack = 0; n_mac = 0; n_clr = 0; n_msg = 0;
  endtask

  task automatic do_pass(input logic [31:0] sz, input bit dm);
    logic [28:0] nb;
    bit idle_seen;
    nb = model_nblk(sz);
    clr_counts();
    push_model(sz, dm);
    bus.size_msg = sz;
    bus.dec_mode = dm;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pass_busy", 64'(bus.busy), 64'd1);
    idle_seen = 1'b0;
    for (int i = 0; i < 500 && !idle_seen; i++) begin
      @(negedge clk);
      if (!bus.busy) idle_seen = 1'b1;
    end
    chk("pass_timeout", 64'(idle_seen), 64'd1);
    chk("pass_q_empty", 64'(exp_q.size()), 64'd0);
    chk("pass_ecb_starts", 64'(n_ecb), 64'(nb) + 64'd1);
    chk("pass_acks", 64'(n_ack), 64'(nb));
    chk("pass_mac", 64'(n_mac), 64'd1);
    chk("pass_msg_cycles", 64'(n_msg), (nb != 0) ? 64'd2 : 64'd0);
    chk("pass_clr", 64'(n_clr), 64'd0);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    ecb_man = 1'b0;
    ecb_en = 1'b1;
    bus.clr_core = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.dec_mode = 1'b0;
    bus.size_msg = 32'd0;
    bus.blk_vld = 1'b1;
    clr_counts();
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 64'(outs()), 64'd0);

    do_pass(32'd32, 1'b0);
    do_pass(32'd17, 1'b1);
    do_pass(32'd0, 1'b0);

    // abort while waiting on the ECB engine; a late ecb_done must do nothing
    ecb_en = 1'b0;
    clr_counts();
    exp_q.push_back(6'b0_1_00_0_0);
    bus.size_msg = 32'd32;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_clr", 64'(bus.ccm_d_clr), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_mac", 64'(bus.mac_done), 64'd0);
    @(negedge clk);
    chk("abort_clr_pulse", 64'(bus.ccm_d_clr), 64'd0);
    ecb_man = 1'b1;
    @(negedge clk);
    ecb_man = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_late_ecb", 64'(outs()), 64'd0);
    chk("abort_q_empty", 64'(exp_q.size()), 64'd0);
    chk("abort_n_clr", 64'(n_clr), 64'd1);
    chk("abort_n_mac", 64'(n_mac), 64'd0);
    ecb_en = 1'b1;

    // clr_core beats blk_vld in MSG_WAIT; start while busy ignored
    clr_counts();
    bus.blk_vld = 1'b0;
    exp_q.push_back(6'b0_1_00_0_0);
    exp_q.push_back(6'b0_1_01_0_0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (bus.ccm_d_en && bus.ccm_d_op == 2'b01) hit = 1'b1;
    end
    chk("clr_ld_ecb_timeout", 64'(hit), 64'd1);
    @(negedge clk);
    chk("clr_mw_busy", 64'(bus.busy), 64'd1);
    chk("clr_mw_msg_done", 64'(bus.msg_done), 64'd0);
    bus.clr_core = 1'b1;
    bus.blk_vld = 1'b1;
    @(negedge clk);
    bus.clr_core = 1'b0;
    bus.blk_vld = 1'b0;
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_ack", 64'(bus.blk_ack), 64'd0);
    chk("clr_dclr", 64'(bus.ccm_d_clr), 64'd0);
    repeat (2) @(negedge clk);
    chk("clr_q_empty", 64'(exp_q.size()), 64'd0);
    chk("clr_n_ack", 64'(n_ack), 64'd0);
    chk("clr_n_ecb", 64'(n_ecb), 64'd1);

    // reset pulse during LD_MSG, then a normal pass right after release
    bus.blk_vld = 1'b1;
    push_model(32'd32, 1'b1);
    bus.dec_mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (bus.blk_ack) hit = 1'b1;
    end
    chk("rst_ld_msg_timeout", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 64'(outs()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    chk("rst_hold_outs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    do_pass(32'd16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
